// File: rtl/bcd_display_pkg.sv
// Shared constants for the multiplexed BCD seven-segment scanner.
// Segment vectors are active-low, bit order gfedcba.
package bcd_display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Nibble to active-low seven-segment decoder; non-BCD nibbles render as 'E'.
module bcd_to_seg7
  import bcd_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_ERR;
    if (nibble <= 4'd9) seg_n = SEG_DIGIT[nibble];
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Eight-digit multiplexed display scanner with frame-synchronous value update,
// leading-zero blanking and a floating minus sign.
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bcd_in,
  input  logic        negative,
  input  logic        load,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        frame_done,
  output logic        sign_hidden
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  logic [31:0]   disp_bcd;
  logic          disp_neg;
  logic [31:0]   pend_bcd;
  logic          pend_neg;
  logic          pend_valid;

  logic [IW-1:0] msd;
  logic [3:0]    sel_nibble;
  logic [6:0]    digit_seg;
  logic [6:0]    seg_next;
  logic          digit7_nz;

  assign tick       = (presc == PRESC_LAST);
  assign wrap       = tick && (idx == IDX_LAST);
  assign frame_done = wrap;

  assign digit7_nz   = (disp_bcd[31:28] != 4'd0);
  assign sign_hidden = disp_neg && digit7_nz;

  // Highest nonzero digit of the shown value; 0 when the value is zero.
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_bcd[i*4 +: 4] != 4'd0) msd = IW'(i);
    end
  end

  assign sel_nibble = disp_bcd[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .nibble (sel_nibble),
    .seg_n  (digit_seg)
  );

  // Minus sits just above the MSD when blanking; without blanking it can
  // only borrow digit 7, and only when that digit is zero.
  always_comb begin
    seg_next = digit_seg;
    if (BLANK_LZ) begin
      if (disp_neg && ({1'b0, idx} == ({1'b0, msd} + 4'd1))) seg_next = SEG_MINUS;
      else if (idx > msd)                                     seg_next = SEG_BLANK;
    end else if (disp_neg && (idx == IDX_LAST) && !digit7_nz) begin
      seg_next = SEG_MINUS;
    end
  end

  // load is a one-cycle strobe with no back-pressure: bcd_in/negative are taken
  // whenever load is high, and the latest pending value is promoted to the
  // display only at the 7->0 wrap so a frame never mixes two values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc      <= '0;
      idx        <= '0;
      disp_bcd   <= '0;
      disp_neg   <= 1'b0;
      pend_bcd   <= '0;
      pend_neg   <= 1'b0;
      pend_valid <= 1'b0;
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 1'b1;

      if (wrap && pend_valid) begin
        disp_bcd <= pend_bcd;
        disp_neg <= pend_neg;
      end

      if (load) begin
        pend_bcd   <= bcd_in;
        pend_neg   <= negative;
        pend_valid <= 1'b1;
      end else if (wrap) begin
        pend_valid <= 1'b0;
      end

      an_n  <= ~(8'd1 << idx);
      seg_n <= seg_next;
    end
  end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is held enabled (legal range 2 or more).
REQ-002 SHALL have parameter BLANK_LZ, default 1, 1 = leading-zero blanking enabled.
REQ-003 SHALL have port clock  in  1  single system clock; all state is on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port bcd_in  in  32  eight packed BCD digits from the upstream binary-to-BCD converter; [3:0] is the least significant digit (index 0).
REQ-006 SHALL have port negative  in  1  sign of the value on bcd_in.
REQ-007 SHALL have port load  in  1  one-cycle strobe; bcd_in and negative are valid in that cycle.
REQ-008 SHALL have port an_n  out  8  active-low digit enables; bit i enables digit index i.
REQ-009 SHALL have port seg_n  out  7  active-low segments, bit order gfedcba.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse when digit index wraps from 7 to 0.
REQ-011 SHALL have port sign_hidden  out  1  high while the displayed value is negative and digit 7 is nonzero.

Function
REQ-012 Prescaler SHALL count 0 to REFRESH_DIV-1 and wrap; at terminal count, digit index SHALL advance 0,1,...,7,0.
REQ-013 On load, bcd_in and negative SHALL be captured into a pending register and pending_valid SHALL be set.
REQ-014 Pending SHALL commit to the display register only at the 7-to-0 index wrap, which prevents mid-frame tearing; commit SHALL clear pending_valid.
REQ-015 If load and commit occur in the same cycle, the old pending value SHALL commit, the new value SHALL be captured into pending, and pending_valid SHALL stay 1.
REQ-016 A second load before commit SHALL overwrite pending (last value wins).
REQ-017 an_n and seg_n SHALL be registered: both SHALL reflect the digit index of the previous cycle, with exactly one an_n bit low when not in reset.
REQ-018 Digits 0-9 SHALL use the standard seven-segment patterns; nibble values 10-15 SHALL show 'E' (seg_n = 0000110).
REQ-019 With BLANK_LZ = 1, digit i (i > 0) SHALL be blank (seg_n = 1111111) when digits i..7 are all zero; digit 0 SHALL never be blanked.
REQ-020 With BLANK_LZ = 1 and negative = 1, digit index MSD+1 SHALL show minus (seg_n = 0111111), where MSD is the highest nonzero digit index (0 if the value is zero).
REQ-021 With BLANK_LZ = 0, no digit SHALL be blanked, and minus SHALL replace digit 7 when negative = 1 and digit 7 = 0.
REQ-022 When negative = 1 and digit 7 is nonzero, no minus SHALL be shown and sign_hidden SHALL be 1.
REQ-023 A value of zero with negative = 1 SHALL display as "-0" (minus at index 1 when BLANK_LZ = 1).
REQ-024 frame_done SHALL assert in the same cycle that commit occurs.

Reset
REQ-025 Reset SHALL force an_n = 11111111, seg_n = 1111111, frame_done = 0, sign_hidden = 0, prescaler = 0, index = 0, display register = 0 (positive), pending_valid = 0.
REQ-026 Reset asserted mid-frame SHALL discard the pending value.
REQ-027 On the first clock edge after reset release, an_n SHALL become 11111110 and seg_n SHALL become the '0' pattern (1000000).

Structure
REQ-028 Package bcd_display_pkg SHALL hold NUM_DIGITS = 8, the segment constants (SEG_BLANK, SEG_MINUS, SEG_ERR) and the digit-pattern table.
REQ-029 Combinational sub-module bcd_to_seg7 (4-bit nibble in, 7-bit seg_n out) SHALL be instantiated once, on the selected digit.
REQ-030 Blanking and sign position SHALL be computed from the display register, never from pending.

Verification (REFRESH_DIV = 4)
REQ-031 Reset, no load: an_n SHALL walk FE, FD, ..., 7F, FE every 4 cycles; digit 0 SHALL show 1000000 and all other digits SHALL be blank.
REQ-032 load bcd_in = 0x00001234, negative = 1: after the next frame_done, digits 0..3 SHALL show 4,3,2,1, index 4 SHALL show minus, and indices 5..7 SHALL be blank.
REQ-033 load 0x00000005 then load 0x00000007 within one frame: only 7 SHALL ever be displayed, and 5 SHALL never appear.
REQ-034 load 0x12345678 with negative = 1: all eight digits SHALL show, sign_hidden = 1, and no minus SHALL appear.
REQ-035 load 0x0000A000: index 3 SHALL show 0000110 ('E'); with BLANK_LZ = 0, indices 4..7 SHALL show '0'.
REQ-036 load asserted in the frame_done cycle, followed by reset mid-frame: outputs SHALL return to reset values and the loaded value SHALL never be displayed.
